// File: rtl/spi_reg_ctrl_if.sv
// Byte-level bus between the SPI slave and the register controller.
// Slave modport is the controller side; master is the SPI slave side.
interface spi_reg_ctrl_if #(
  parameter int NREGS = 8
);
  localparam int AW = $clog2(NREGS);

  logic          frame_active;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic [7:0]    tx_byte;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [7:0]    leds;
  logic          cmd_err;
  logic          busy;

  modport slave (
    input  frame_active, rx_valid, rx_byte,
    output tx_byte, wr_strobe, wr_addr, wr_data,
    output leds, cmd_err, busy
  );

  modport master (
    output frame_active, rx_valid, rx_byte,
    input  tx_byte, wr_strobe, wr_addr, wr_data,
    input  leds, cmd_err, busy
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI command sequencer: decodes write/read/ID/status/clear frames,
// owns the register file and picks the next MISO byte.
module spi_reg_ctrl #(
  parameter int         NREGS     = 8,
  parameter logic [7:0] DEVICE_ID = 8'hA5
) (
  input  logic           clk,
  input  logic           rst,
  spi_reg_ctrl_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [2:0] {
    IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA, ID, DISCARD
  } state_t;

  state_t        state, state_n;
  logic [7:0]    regs [NREGS];
  logic [AW-1:0] addr, addr_n;
  logic [6:0]    wr_count, cnt_n;
  logic [7:0]    tx_q, tx_n;
  logic          err_q, err_n;
  logic          we;
  logic          in_range;
  logic [AW-1:0] rx_addr;

  assign in_range = bus.rx_byte < 8'(NREGS);
  assign rx_addr  = bus.rx_byte[AW-1:0];

  assign bus.tx_byte = tx_q;
  assign bus.cmd_err = err_q;
  assign bus.leds    = regs[0];
  assign bus.busy    = (state != IDLE);

  // State register; everything else lives in the datapath block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Command decode: next state, next MISO byte, pointer and flags.
  always_comb begin
    state_n = state;
    tx_n    = tx_q;
    addr_n  = addr;
    err_n   = err_q;
    cnt_n   = wr_count;
    we      = 1'b0;
    if (!bus.frame_active) begin
      state_n = IDLE;
      tx_n    = 8'h00;
    end else if (bus.rx_valid) begin
      unique case (state)
        IDLE: begin
          unique case (bus.rx_byte)
            8'h02: state_n = W_ADDR;
            8'h03: state_n = R_ADDR;
            8'h9F: begin
              state_n = ID;
              tx_n    = DEVICE_ID;
            end
            8'h05: begin
              state_n = DISCARD;
              tx_n    = {err_q, wr_count};
            end
            8'h06: begin
              state_n = DISCARD;
              err_n   = 1'b0;
              tx_n    = 8'h00;
            end
            default: begin
              state_n = DISCARD;
              err_n   = 1'b1;
              tx_n    = 8'hFF;
            end
          endcase
        end
        W_ADDR, R_ADDR: begin
          if (!in_range) begin
            state_n = DISCARD;
            err_n   = 1'b1;
            tx_n    = 8'hFF;
          end else if (state == W_ADDR) begin
            state_n = W_DATA;
            addr_n  = rx_addr;
          end else begin
            state_n = R_DATA;
            tx_n    = regs[rx_addr];
            addr_n  = rx_addr + AW'(1);
          end
        end
        W_DATA: begin
          we     = 1'b1;
          addr_n = addr + AW'(1);
          cnt_n  = wr_count + 7'd1;
        end
        R_DATA: begin
          tx_n   = regs[addr];
          addr_n = addr + AW'(1);
        end
        ID:      tx_n = DEVICE_ID;
        DISCARD: tx_n = tx_q;
        default: state_n = IDLE;
      endcase
    end
  end

  // Datapath registers, register file and write-strobe outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
      addr          <= '0;
      wr_count      <= '0;
      tx_q          <= 8'h00;
      err_q         <= 1'b0;
      bus.wr_strobe <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= 8'h00;
    end else begin
      addr          <= addr_n;
      wr_count      <= cnt_n;
      tx_q          <= tx_n;
      err_q         <= err_n;
      bus.wr_strobe <= we;
      if (we) begin
        regs[addr]  <= bus.rx_byte;
        bus.wr_addr <= addr;
        bus.wr_data <= bus.rx_byte;
      end
    end
  end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl with NREGS=8.
// Expected values are hand-computed per step.
module tb_spi_reg_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  spi_reg_ctrl_if #(.NREGS(8)) bus ();

  spi_reg_ctrl #(
    .NREGS(8),
    .DEVICE_ID(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Free-running clock, posedges at 5, 15, ...
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic start_frame;
    @(negedge clk);
    bus.frame_active = 1'b1;
  endtask

  task automatic end_frame;
    @(negedge clk);
    bus.frame_active = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.frame_active = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.rx_byte      = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_tx", bus.tx_byte, 8'h00);
    check("rst_strobe", bus.wr_strobe, 1'b0);
    check("rst_waddr", bus.wr_addr, 3'd0);
    check("rst_wdata", bus.wr_data, 8'h00);
    check("rst_leds", bus.leds, 8'h00);
    check("rst_err", bus.cmd_err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);

    // Single write to reg 0
    start_frame();
    send(8'h02);
    check("w1_busy", bus.busy, 1'b1);
    check("w1_first_tx", bus.tx_byte, 8'h00);
    send(8'h00);
    check("w1_nostrobe_addr", bus.wr_strobe, 1'b0);
    send(8'h5A);
    check("w1_strobe", bus.wr_strobe, 1'b1);
    check("w1_waddr", bus.wr_addr, 3'd0);
    check("w1_wdata", bus.wr_data, 8'h5A);
    check("w1_leds", bus.leds, 8'h5A);
    @(negedge clk);
    check("w1_strobe_1clk", bus.wr_strobe, 1'b0);
    check("w1_busy_in_frame", bus.busy, 1'b1);
    end_frame();
    check("w1_busy_end", bus.busy, 1'b0);

    // Burst write across the wrap point
    start_frame();
    send(8'h02);
    send(8'h07);
    send(8'h11);
    check("bw_waddr7", bus.wr_addr, 3'd7);
    check("bw_wdata11", bus.wr_data, 8'h11);
    send(8'h22);
    check("bw_strobe", bus.wr_strobe, 1'b1);
    check("bw_waddr0", bus.wr_addr, 3'd0);
    check("bw_leds", bus.leds, 8'h22);
    end_frame();

    // Burst read across the wrap point
    start_frame();
    send(8'h03);
    send(8'h07);
    check("br_r7", bus.tx_byte, 8'h11);
    send(8'hC3);
    check("br_r0", bus.tx_byte, 8'h22);
    @(negedge clk);
    @(negedge clk);
    check("br_hold", bus.tx_byte, 8'h22);
    end_frame();
    check("br_end_tx", bus.tx_byte, 8'h00);

    // ID command
    start_frame();
    send(8'h9F);
    check("id_1", bus.tx_byte, 8'hA5);
    send(8'h00);
    check("id_2", bus.tx_byte, 8'hA5);
    send(8'hFF);
    check("id_3", bus.tx_byte, 8'hA5);
    check("id_err", bus.cmd_err, 1'b0);
    end_frame();

    // Unknown command, then status, then clear
    start_frame();
    send(8'h7E);
    check("bad_err", bus.cmd_err, 1'b1);
    check("bad_tx", bus.tx_byte, 8'hFF);
    send(8'h02);
    check("bad_discard", bus.tx_byte, 8'hFF);
    end_frame();
    check("bad_err_sticky", bus.cmd_err, 1'b1);
    start_frame();
    send(8'h05);
    check("status", bus.tx_byte, 8'h83);
    end_frame();
    start_frame();
    send(8'h06);
    check("clr_err", bus.cmd_err, 1'b0);
    check("clr_tx", bus.tx_byte, 8'h00);
    end_frame();

    // Out-of-range write address
    start_frame();
    send(8'h02);
    send(8'h08);
    check("oor_err", bus.cmd_err, 1'b1);
    check("oor_tx", bus.tx_byte, 8'hFF);
    send(8'h99);
    check("oor_nowrite", bus.wr_strobe, 1'b0);
    end_frame();
    start_frame();
    send(8'h06);
    end_frame();

    // Frame dropped in the same cycle as the data byte
    start_frame();
    send(8'h02);
    send(8'h03);
    @(negedge clk);
    bus.rx_valid     = 1'b1;
    bus.rx_byte      = 8'h77;
    bus.frame_active = 1'b0;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("abort_strobe", bus.wr_strobe, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_tx", bus.tx_byte, 8'h00);
    start_frame();
    send(8'h03);
    send(8'h03);
    check("abort_reg3", bus.tx_byte, 8'h00);
    end_frame();

    // Status after abort: still 3 writes
    start_frame();
    send(8'h05);
    check("status2", bus.tx_byte, 8'h03);
    end_frame();

    // Asynchronous reset in the middle of a burst write
    start_frame();
    send(8'h02);
    send(8'h01);
    send(8'h44);
    check("rb_wdata", bus.wr_data, 8'h44);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h55;
    #2;
    rst = 1'b1;
    #1;
    check("ar_tx", bus.tx_byte, 8'h00);
    check("ar_strobe", bus.wr_strobe, 1'b0);
    check("ar_waddr", bus.wr_addr, 3'd0);
    check("ar_wdata", bus.wr_data, 8'h00);
    check("ar_leds", bus.leds, 8'h00);
    check("ar_err", bus.cmd_err, 1'b0);
    check("ar_busy", bus.busy, 1'b0);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h9F);
    check("ar_cmd_id", bus.tx_byte, 8'hA5);
    end_frame();
    start_frame();
    send(8'h05);
    check("ar_status", bus.tx_byte, 8'h00);
    end_frame();
    start_frame();
    send(8'h03);
    send(8'h01);
    check("ar_reg1", bus.tx_byte, 8'h00);
    end_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
